// File: rtl/axis_frame_gen.sv
// AXI4-Stream grey-scale test-pattern frame source with line/frame blanking and back-pressure.
// Optional stall counter on o_stall_cnt is enabled by defining AXIS_FRAME_GEN_STALL_CNT_EN.
`timescale 1ns/1ps
module axis_frame_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int H_BLANK    = 4,
    parameter int V_BLANK    = 16
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_reset,
    input  logic                  i_start,
    input  logic                  i_continuous,
    input  logic [1:0]            i_pattern,
    input  logic [DATA_WIDTH-1:0] i_const_val,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic [31:0]           o_stall_cnt
);

    localparam int XW   = $clog2(IMG_WIDTH);
    localparam int YW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW   = (BMAX > 0) ? $clog2(BMAX + 1) : 1;
    localparam int EW   = DATA_WIDTH + XW + YW + 4;

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [BW-1:0] HB_LOAD = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [BW-1:0] VB_LOAD = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [BW-1:0]         blank_q, blank_d;
    logic [1:0]            pat_q, pat_d;
    logic [DATA_WIDTH-1:0] cval_q, cval_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tuser_q, tuser_d;
    logic                  tlast_q, tlast_d;
    logic                  busy_q;
    logic                  done_q, done_d;
    logic                  hs, present, new_frame;

    function automatic logic [DATA_WIDTH-1:0] pixel(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                                    input logic [1:0] pat,
                                                    input logic [DATA_WIDTH-1:0] cval);
        logic [EW-1:0] xe, ye;
        xe = EW'(x);
        ye = EW'(y);
        case (pat)
            2'd0:    pixel = xe[DATA_WIDTH-1:0];
            2'd1:    pixel = ye[DATA_WIDTH-1:0];
            2'd2:    pixel = (xe[3] ^ ye[3]) ? '1 : '0;
            default: pixel = cval;
        endcase
    endfunction

    assign hs = tvalid_q & m_axis_tready;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        blank_d   = blank_q;
        pat_d     = pat_q;
        cval_d    = cval_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;
        done_d    = 1'b0;
        present   = 1'b0;
        new_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_ACTIVE;
                    new_frame = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (hs) begin
                    if (x_q != X_LAST) begin
                        x_d     = x_q + 1'b1;
                        present = 1'b1;
                    end else if (y_q != Y_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                        if (H_BLANK > 0) begin
                            state_d = S_HBLANK;
                            blank_d = HB_LOAD;
                        end else begin
                            present = 1'b1;
                        end
                    end else begin
                        x_d    = '0;
                        y_d    = '0;
                        done_d = 1'b1;
                        if (!i_continuous) begin
                            state_d = S_IDLE;
                        end else if (V_BLANK > 0) begin
                            state_d = S_VBLANK;
                            blank_d = VB_LOAD;
                        end else begin
                            new_frame = 1'b1;
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (blank_q == '0) begin
                    state_d = S_ACTIVE;
                    present = 1'b1;
                end else begin
                    blank_d = blank_q - 1'b1;
                end
            end
            default: begin
                if (blank_q == '0) begin
                    if (i_continuous) begin
                        state_d   = S_ACTIVE;
                        new_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    blank_d = blank_q - 1'b1;
                end
            end
        endcase

        // Pattern and constant are captured only when a frame's first pixel is launched.
        if (new_frame) begin
            x_d     = '0;
            y_d     = '0;
            pat_d   = i_pattern;
            cval_d  = i_const_val;
            present = 1'b1;
        end

        if (present) begin
            tvalid_d = 1'b1;
            tdata_d  = pixel(x_d, y_d, pat_d, cval_d);
            tuser_d  = (x_d == '0) && (y_d == '0);
            tlast_d  = (x_d == X_LAST);
        end else if (state_d != S_ACTIVE) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tuser_d  = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            blank_q  <= '0;
            pat_q    <= '0;
            cval_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            blank_q  <= blank_d;
            pat_q    <= pat_d;
            cval_q   <= cval_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= done_d;
        end
    end

`ifdef AXIS_FRAME_GEN_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (tvalid_q && !m_axis_tready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (new_frame) begin
            stall_d = '0;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`else
    assign o_stall_cnt = '0;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Randomised self-checking bench for axis_frame_gen: beats are captured and compared with a
// frame model built from x/y arithmetic; a 16x16 zero-blank instance covers the checker pattern.
`timescale 1ns/1ps
module tb_axis_frame_gen;
    localparam int W = 8, H = 4, HB = 2, VB = 3, W2 = 16, H2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start1, start2, cont, tready;
    logic [1:0] pat;
    logic [7:0] cval;

    logic [7:0]  d1_data, d2_data;
    logic        d1_valid, d1_user, d1_last, d1_busy, d1_done;
    logic        d2_valid, d2_user, d2_last, d2_busy, d2_done;
    logic [31:0] d1_stall, d2_stall;

    axis_frame_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .i_sys_clk(clk), .i_sys_reset(rst), .i_start(start1), .i_continuous(cont),
        .i_pattern(pat), .i_const_val(cval),
        .m_axis_tdata(d1_data), .m_axis_tvalid(d1_valid), .m_axis_tuser(d1_user),
        .m_axis_tlast(d1_last), .m_axis_tready(tready),
        .o_busy(d1_busy), .o_frame_done(d1_done), .o_stall_cnt(d1_stall));

    axis_frame_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W2), .IMG_HEIGHT(H2), .H_BLANK(0), .V_BLANK(0)) dut2 (
        .i_sys_clk(clk), .i_sys_reset(rst), .i_start(start2), .i_continuous(cont),
        .i_pattern(pat), .i_const_val(cval),
        .m_axis_tdata(d2_data), .m_axis_tvalid(d2_valid), .m_axis_tuser(d2_user),
        .m_axis_tlast(d2_last), .m_axis_tready(tready),
        .o_busy(d2_busy), .o_frame_done(d2_done), .o_stall_cnt(d2_stall));

    bit          sel = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid, m_user, m_last, m_busy, m_done;
    logic [31:0] m_stall;

    always_comb begin
        m_data  = sel ? d2_data  : d1_data;
        m_valid = sel ? d2_valid : d1_valid;
        m_user  = sel ? d2_user  : d1_user;
        m_last  = sel ? d2_last  : d1_last;
        m_busy  = sel ? d2_busy  : d1_busy;
        m_done  = sel ? d2_done  : d1_done;
        m_stall = sel ? d2_stall : d1_stall;
    end

    logic [7:0] bd[$];
    logic       bu[$], bl[$];
    int         bc[$], done_cyc[$];
    int         stalls, stable_err;
    bit         timeout;
    int         pat_at = -1, cont_off_at = -1, pulse_at = -1;
    logic [1:0] pat_new;
    int         tests_run = 0, tests_failed = 0;

    function automatic logic [7:0] model_pix(int x, int y, int p, int cv);
        case (p)
            0:       return 8'(x % 256);
            1:       return 8'(y % 256);
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
            default: return 8'(cv);
        endcase
    endfunction

    // Captures handshaken beats until nbeats are seen, then watches 'extra' more cycles.
    task automatic collect(input int nbeats, input int extra, input bit rnd, input int maxcyc);
        int cyc = 0, post = 0;
        bit pstall = 1'b0;
        logic [7:0] pd;
        logic pu, pl;
        bd.delete(); bu.delete(); bl.delete(); bc.delete(); done_cyc.delete();
        stalls = 0; stable_err = 0; timeout = 1'b0;
        forever begin
            if (bd.size() >= nbeats) begin
                if (post >= extra) break;
                post++;
            end
            if (cyc >= maxcyc) begin
                timeout = 1'b1;
                break;
            end
            if (pat_at >= 0 && bd.size() == pat_at) pat = pat_new;
            if (cont_off_at >= 0 && bd.size() == cont_off_at) cont = 1'b0;
            if (pulse_at >= 0) start1 = (bd.size() == pulse_at);
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pstall && (m_valid !== 1'b1 || m_data !== pd || m_user !== pu || m_last !== pl))
                stable_err++;
            if (m_done === 1'b1) done_cyc.push_back(cyc);
            pstall = 1'b0;
            if (m_valid === 1'b1) begin
                if (tready) begin
                    bd.push_back(m_data); bu.push_back(m_user); bl.push_back(m_last); bc.push_back(cyc);
                end else begin
                    stalls++;
                    pstall = 1'b1; pd = m_data; pu = m_user; pl = m_last;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({d1_valid, d1_user, d1_last, d1_busy, d1_done, d1_data, d1_stall} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got v%b u%b l%b b%b d%b data %0h stall %0d required all 0",
                     d1_valid, d1_user, d1_last, d1_busy, d1_done, d1_data, d1_stall);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (d1_busy !== 1'b0 || d1_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle got busy %b valid %b required 0 0", d1_busy, d1_valid);
        end
    endtask

    task automatic test_hramp();
        sel = 1'b0; pat = 2'd0; cont = 1'b0; tready = 1'b1;
        start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
        collect(W * H, 3, 1'b0, 400);
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL hramp_timeout got %0d beats required %0d", bd.size(), W * H); end
        for (int i = 0; i < W * H; i++) begin
            tests_run++;
            if (bd[i] !== model_pix(i % W, i / W, 0, 0) || bu[i] !== (i == 0) || bl[i] !== (i % W == W - 1)) begin
                tests_failed++;
                $display("FAIL hramp_beat%0d got data %0h user %b last %b required %0h %b %b", i, bd[i], bu[i], bl[i],
                         model_pix(i % W, i / W, 0, 0), (i == 0), (i % W == W - 1));
            end
        end
        tests_run++;
        if (bc[W*H-1] - bc[0] + 1 !== W * H + (H - 1) * HB) begin
            tests_failed++; $display("FAIL hramp_span got %0d required %0d", bc[W*H-1] - bc[0] + 1, W * H + (H - 1) * HB);
        end
        tests_run++;
        if (bc[W] - bc[W-1] - 1 !== HB) begin tests_failed++; $display("FAIL hramp_hgap got %0d required %0d", bc[W] - bc[W-1] - 1, HB); end
        tests_run++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== bc[W*H-1] + 1) begin
            tests_failed++; $display("FAIL hramp_done got count %0d cyc %0d required 1 at %0d", done_cyc.size(), done_cyc[0], bc[W*H-1] + 1);
        end
        tests_run++;
        if (m_busy !== 1'b0 || m_stall !== 32'd0) begin
            tests_failed++; $display("FAIL hramp_end got busy %b stall %0d required 0 0", m_busy, m_stall);
        end
    endtask

    task automatic test_backpressure();
        int exp_stall;
        sel = 1'b0; pat = 2'd0; cont = 1'b0; tready = 1'b0;
        start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
        collect(W * H, 2, 1'b1, 2000);
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout got %0d beats required %0d", bd.size(), W * H); end
        for (int i = 0; i < W * H; i++) begin
            tests_run++;
            if (bd[i] !== model_pix(i % W, i / W, 0, 0) || bu[i] !== (i == 0) || bl[i] !== (i % W == W - 1)) begin
                tests_failed++;
                $display("FAIL bp_beat%0d got data %0h user %b last %b required %0h %b %b", i, bd[i], bu[i], bl[i],
                         model_pix(i % W, i / W, 0, 0), (i == 0), (i % W == W - 1));
            end
        end
        tests_run++;
        if (stable_err !== 0) begin tests_failed++; $display("FAIL bp_stable got %0d unstable stalls required 0", stable_err); end
`ifdef AXIS_FRAME_GEN_STALL_CNT_EN
        exp_stall = stalls;
`else
        exp_stall = 0;
`endif
        tests_run++;
        if (m_stall !== 32'(exp_stall)) begin tests_failed++; $display("FAIL bp_stall_cnt got %0d required %0d", m_stall, exp_stall); end
        tests_run++;
        if (done_cyc.size() !== 1 || m_busy !== 1'b0) begin
            tests_failed++; $display("FAIL bp_done got count %0d busy %b required 1 0", done_cyc.size(), m_busy);
        end
    endtask

    task automatic test_continuous();
        sel = 1'b0; pat = 2'd0; cont = 1'b1; tready = 1'b1;
        pat_at = 10; pat_new = 2'd1; cont_off_at = W * H + 8;
        start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
        collect(2 * W * H, 3, 1'b0, 600);
        pat_at = -1; cont_off_at = -1;
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL cont_timeout got %0d beats required %0d", bd.size(), 2 * W * H); end
        for (int i = 0; i < 2 * W * H; i++) begin
            int f, j;
            f = i / (W * H); j = i % (W * H);
            tests_run++;
            if (bd[i] !== model_pix(j % W, j / W, f, 0) || bu[i] !== (j == 0) || bl[i] !== (j % W == W - 1)) begin
                tests_failed++;
                $display("FAIL cont_beat%0d got data %0h user %b last %b required %0h %b %b", i, bd[i], bu[i], bl[i],
                         model_pix(j % W, j / W, f, 0), (j == 0), (j % W == W - 1));
            end
        end
        tests_run++;
        if (bc[W*H] - bc[W*H-1] - 1 !== VB) begin
            tests_failed++; $display("FAIL cont_vgap got %0d required %0d", bc[W*H] - bc[W*H-1] - 1, VB);
        end
        tests_run++;
        if (done_cyc.size() !== 2 || m_busy !== 1'b0) begin
            tests_failed++; $display("FAIL cont_done got count %0d busy %b required 2 0", done_cyc.size(), m_busy);
        end
        pat = 2'd0;
    endtask

    task automatic test_checker();
        sel = 1'b1; pat = 2'd2; cont = 1'b0; tready = 1'b1;
        start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
        collect(W2 * H2, 2, 1'b0, 1000);
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("FAIL chk_timeout got %0d beats required %0d", bd.size(), W2 * H2); end
        tests_run++;
        if ({bd[0], bd[8], bd[8*W2], bd[8*W2+8]} !== 32'h00FF_FF00) begin
            tests_failed++;
            $display("FAIL chk_corners got %0h %0h %0h %0h required 00 ff ff 00", bd[0], bd[8], bd[8*W2], bd[8*W2+8]);
        end
        for (int i = 0; i < W2 * H2; i++) begin
            tests_run++;
            if (bd[i] !== model_pix(i % W2, i / W2, 2, 0) || bl[i] !== (i % W2 == W2 - 1)) begin
                tests_failed++;
                $display("FAIL chk_beat%0d got data %0h last %b required %0h %b", i, bd[i], bl[i],
                         model_pix(i % W2, i / W2, 2, 0), (i % W2 == W2 - 1));
            end
        end
        tests_run++;
        if (bc[W2*H2-1] - bc[0] + 1 !== W2 * H2 || done_cyc.size() !== 1) begin
            tests_failed++;
            $display("FAIL chk_span got %0d done %0d required %0d 1", bc[W2*H2-1] - bc[0] + 1, done_cyc.size(), W2 * H2);
        end
        sel = 1'b0; pat = 2'd0;
    endtask

    task automatic test_reset_midframe();
        int seen;
        sel = 1'b0; pat = 2'd0; cont = 1'b0; tready = 1'b1;
        start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
        collect(11, 0, 1'b0, 200);
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_abort got valid %b busy %b required 0 0", m_valid, m_busy);
        end
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (m_valid !== 1'b0 || m_done !== 1'b0 || m_last !== 1'b0) seen++;
        end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL rstmid_quiet got %0d active cycles required 0", seen); end
        start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
        tests_run++;
        if (m_valid !== 1'b1 || m_user !== 1'b1 || m_data !== 8'h00) begin
            tests_failed++; $display("FAIL rstmid_restart got valid %b user %b data %0h required 1 1 00", m_valid, m_user, m_data);
        end
        collect(W * H, 2, 1'b0, 400);
        tests_run++;
        if (done_cyc.size() !== 1 || bd[W*H-1] !== model_pix(W - 1, H - 1, 0, 0)) begin
            tests_failed++; $display("FAIL rstmid_finish got done %0d last data %0h required 1 %0h", done_cyc.size(), bd[W*H-1],
                                     model_pix(W - 1, H - 1, 0, 0));
        end
    endtask

    task automatic test_start_ignored();
        int act;
        sel = 1'b0; pat = 2'd3; cval = 8'($urandom_range(0, 255)); cont = 1'b0; tready = 1'b1;
        rst = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start1 = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
            tests_failed++; $display("FAIL start_with_reset got valid %b busy %b required 0 0", m_valid, m_busy);
        end
        pulse_at = W;
        start1 = 1'b1; @(posedge clk); #1;
        collect(W * H, 3, 1'b0, 400);
        pulse_at = -1; start1 = 1'b0;
        tests_run++;
        if (bc[W*H-1] - bc[0] + 1 !== W * H + (H - 1) * HB || done_cyc.size() !== 1) begin
            tests_failed++; $display("FAIL start_busy_span got %0d done %0d required %0d 1",
                                     bc[W*H-1] - bc[0] + 1, done_cyc.size(), W * H + (H - 1) * HB);
        end
        tests_run++;
        if (bd[W+1] !== model_pix(1, 1, 3, int'(cval)) || bu[W] !== 1'b0) begin
            tests_failed++; $display("FAIL start_busy_data got %0h user %b required %0h 0", bd[W+1], bu[W], cval);
        end
        act = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (m_valid !== 1'b0 || m_busy !== 1'b0) act++;
        end
        tests_run++;
        if (act !== 0) begin tests_failed++; $display("FAIL start_busy_after got %0d active cycles required 0", act); end
        pat = 2'd0;
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; cont = 1'b0; pat = 2'd0; cval = 8'h00; tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_hramp();
        test_backpressure();
        test_continuous();
        test_checker();
        test_reset_midframe();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
